// File: rtl/lut_eval_reg.sv
// Reconfigurable K-input logic function cell.
// A 2^K-entry truth table, loaded serially into a shadow register and committed
// atomically, selects one bit per accepted evaluation; the result is registered.
module lut_eval_reg #(
  parameter int unsigned        K           = 2,
  parameter logic [(1<<K)-1:0]  RESET_TABLE = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cfg_start,
  input  logic         i_cfg_valid,
  input  logic         i_cfg_bit,
  output logic         o_cfg_busy,
  output logic         o_cfg_done,
  input  logic [K-1:0] i_sel,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  output logic         o_out,
  output logic         o_out_valid
);

  localparam int unsigned Depth = 1 << K;
  // One spare bit so a depth-2 table still gets a well-formed counter.
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned IdxW  = CntW - 1;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  state_e            r_state,     w_state_next;
  logic [Depth-1:0]  r_table,     w_table_next;
  logic [Depth-1:0]  r_shadow,    w_shadow_next;
  logic [CntW-1:0]   r_cnt,       w_cnt_next;
  logic              r_out,       w_out_next;
  logic              r_out_valid, w_out_valid_next;
  logic              r_cfg_done,  w_cfg_done_next;
  logic              w_last;

  assign w_last = (r_cnt == CntW'(Depth - 1));

  // State and datapath registers; reset discards any partial load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_table     <= RESET_TABLE;
      r_shadow    <= '0;
      r_cnt       <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_cfg_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_table     <= w_table_next;
      r_shadow    <= w_shadow_next;
      r_cnt       <= w_cnt_next;
      r_out       <= w_out_next;
      r_out_valid <= w_out_valid_next;
      r_cfg_done  <= w_cfg_done_next;
    end
  end

  // Next-state: evaluate in IDLE, shift table bits into the shadow in LOAD.
  always_comb begin
    w_state_next     = r_state;
    w_table_next     = r_table;
    w_shadow_next    = r_shadow;
    w_cnt_next       = r_cnt;
    w_out_next       = r_out;
    w_out_valid_next = 1'b0;
    w_cfg_done_next  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // An evaluation coinciding with cfg_start still uses the old table.
        if (i_in_valid) begin
          w_out_next       = r_table[i_sel];
          w_out_valid_next = 1'b1;
        end
        if (i_cfg_start) begin
          w_state_next = StLoad;
          w_cnt_next   = '0;
        end
      end
      StLoad: begin
        if (i_cfg_start) begin
          // Restart: the bit offered this cycle is dropped.
          w_cnt_next = '0;
        end else if (i_cfg_valid) begin
          w_shadow_next[r_cnt[IdxW-1:0]] = i_cfg_bit;
          if (w_last) begin
            w_table_next    = w_shadow_next;
            w_cfg_done_next = 1'b1;
            w_state_next    = StIdle;
            w_cnt_next      = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_cfg_busy  = (r_state == StLoad);
  assign o_cfg_done  = r_cfg_done;
  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_lut_eval_reg.sv
// Bench for lut_eval_reg: a K=2 and a K=1 instance checked cycle by cycle
// against a truth-table model, with directed scenarios then random traffic.
module tb_lut_eval_reg;

  logic       clk;
  logic       rst_n;
  logic [1:0] cfg_start, cfg_valid, cfg_bit, in_valid;
  logic [1:0] sel2;
  logic [0:0] sel1;
  logic [1:0] busy_w, done_w, ready_w, out_w, ov_w;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: active table as an integer, shadow built by shifting bits in.
  int m_depth [2] = '{4, 2};
  int m_rt    [2] = '{0, 2};
  bit m_load  [2];
  int m_table [2];
  int m_shadow[2];
  int m_cnt   [2];
  bit m_out   [2];
  bit m_ov    [2];
  bit m_done  [2];
  int done_cnt[2];

  lut_eval_reg #(.K(2), .RESET_TABLE(4'b0000)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_start(cfg_start[0]), .i_cfg_valid(cfg_valid[0]), .i_cfg_bit(cfg_bit[0]),
    .o_cfg_busy(busy_w[0]), .o_cfg_done(done_w[0]),
    .i_sel(sel2), .i_in_valid(in_valid[0]), .o_in_ready(ready_w[0]),
    .o_out(out_w[0]), .o_out_valid(ov_w[0])
  );

  lut_eval_reg #(.K(1), .RESET_TABLE(2'b10)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_start(cfg_start[1]), .i_cfg_valid(cfg_valid[1]), .i_cfg_bit(cfg_bit[1]),
    .o_cfg_busy(busy_w[1]), .o_cfg_done(done_w[1]),
    .i_sel(sel1), .i_in_valid(in_valid[1]), .o_in_ready(ready_w[1]),
    .o_out(out_w[1]), .o_out_valid(ov_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int get_sel(input int d);
    return (d == 0) ? int'(sel2) : int'(sel1);
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_load[d] = 0; m_table[d] = m_rt[d]; m_shadow[d] = 0; m_cnt[d] = 0;
      m_out[d] = 0; m_ov[d] = 0; m_done[d] = 0;
    end
  endfunction

  function automatic void model_edge(input int d);
    m_done[d] = 0;
    m_ov[d]   = 0;
    if (!m_load[d]) begin
      if (in_valid[d]) begin
        m_out[d] = bit'((m_table[d] >> get_sel(d)) & 1);
        m_ov[d]  = 1;
      end
      if (cfg_start[d]) begin
        m_load[d] = 1; m_cnt[d] = 0; m_shadow[d] = 0;
      end
    end else if (cfg_start[d]) begin
      m_cnt[d] = 0; m_shadow[d] = 0;
    end else if (cfg_valid[d]) begin
      m_shadow[d] |= int'(cfg_bit[d]) << m_cnt[d];
      m_cnt[d]++;
      if (m_cnt[d] == m_depth[d]) begin
        m_table[d] = m_shadow[d];
        m_done[d]  = 1;
        m_load[d]  = 0;
      end
    end
  endfunction

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out[%0d]", d),       32'(out_w[d]),   32'(m_out[d]));
      chk($sformatf("out_valid[%0d]", d), 32'(ov_w[d]),    32'(m_ov[d]));
      chk($sformatf("cfg_done[%0d]", d),  32'(done_w[d]),  32'(m_done[d]));
      chk($sformatf("in_ready[%0d]", d),  32'(ready_w[d]), 32'(!m_load[d]));
      chk($sformatf("cfg_busy[%0d]", d),  32'(busy_w[d]),  32'(m_load[d]));
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) for (int d = 0; d < 2; d++) model_edge(d);
    @(negedge clk);
    for (int d = 0; d < 2; d++) done_cnt[d] += int'(done_w[d]);
    check_all();
  endtask

  task automatic clear_inputs();
    cfg_start = '0; cfg_valid = '0; cfg_bit = '0; in_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1;
  endtask

  // Serial load of n bits (bits[i] sent i-th); gaps stall with in_valid held high.
  task automatic load(input int d, input int bits, input int n, input bit gaps);
    cfg_start[d] = 1'b1;
    step();
    cfg_start[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        cfg_valid[d] = 1'b0; in_valid[d] = 1'b1;
        step();
        in_valid[d] = 1'b0;
      end
      cfg_valid[d] = 1'b1;
      cfg_bit[d]   = 1'((bits >> i) & 1);
      step();
    end
    cfg_valid[d] = 1'b0;
  endtask

  task automatic eval(input int d, input int s, input bit exp);
    if (d == 0) sel2 = 2'(s); else sel1 = 1'(s);
    in_valid[d] = 1'b1;
    step();
    in_valid[d] = 1'b0;
    chk($sformatf("eval[%0d] sel=%0d", d, s), 32'(out_w[d]), 32'(exp));
  endtask

  initial begin
    int dc;
    clear_inputs();
    sel2 = '0; sel1 = '0;
    done_cnt = '{0, 0};
    do_reset();

    // Reset table of the K=2 cell is all zero.
    eval(0, 3, 1'b0);
    chk("reset out_valid", 32'(ov_w[0]), 32'd1);

    // Implication, one commit pulse.
    dc = done_cnt[0];
    load(0, 'b1011, 4, 1'b0);
    chk("impl done at last bit", 32'(done_w[0]), 32'd1);
    step();
    chk("impl done pulses", 32'(done_cnt[0] - dc), 32'd1);
    eval(0, 0, 1'b1); eval(0, 1, 1'b1); eval(0, 2, 1'b0); eval(0, 3, 1'b1);

    // Asynchronous reset mid-cycle with out = 1 and out_valid = 1.
    eval(0, 0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out", 32'(out_w[0]), 32'd0);
    chk("async rst out_valid", 32'(ov_w[0]), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Stalled load with evaluation requests during the load.
    load(0, 'b1011, 4, 1'b1);
    step();
    eval(0, 2, 1'b0); eval(0, 3, 1'b1);

    // NAND, then an aborted XOR, then NOR.
    load(0, 'b0111, 4, 1'b0);
    step();
    eval(0, 3, 1'b0);
    load(0, 'b0110, 2, 1'b0);
    cfg_valid[0] = 1'b1; cfg_bit[0] = 1'b1; cfg_start[0] = 1'b1;
    step();
    cfg_start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cfg_bit[0] = 1'((4'b0001 >> i) & 1);
      step();
    end
    cfg_valid[0] = 1'b0;
    eval(0, 0, 1'b1); eval(0, 1, 1'b0); eval(0, 3, 1'b0);

    // cfg_start together with in_valid uses the old table.
    load(0, 'b1011, 4, 1'b0);
    step();
    sel2 = 2'b10; in_valid[0] = 1'b1; cfg_start[0] = 1'b1;
    step();
    in_valid[0] = 1'b0; cfg_start[0] = 1'b0;
    chk("simul out", 32'(out_w[0]), 32'd0);
    chk("simul out_valid", 32'(ov_w[0]), 32'd1);
    chk("simul busy", 32'(busy_w[0]), 32'd1);
    cfg_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_bit[0] = 1'((4'b1011 >> i) & 1);
      step();
    end
    cfg_valid[0] = 1'b0;
    step();

    // K = 1: NOT, then a load cut short by reset.
    load(1, 'b01, 2, 1'b0);
    step();
    eval(1, 0, 1'b1); eval(1, 1, 1'b0);
    load(1, 'b11, 1, 1'b0);
    do_reset();
    eval(1, 0, 1'b0); eval(1, 1, 1'b1);

    // Random traffic on both cells.
    for (int c = 0; c < 4000; c++) begin
      for (int d = 0; d < 2; d++) begin
        cfg_start[d] = ($urandom_range(0, 15) == 0);
        cfg_valid[d] = ($urandom_range(0, 9) < 6);
        cfg_bit[d]   = 1'($urandom_range(0, 1));
        in_valid[d]  = 1'($urandom_range(0, 1));
      end
      sel2 = 2'($urandom_range(0, 3));
      sel1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) begin
        clear_inputs();
        do_reset();
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
